// File: rtl/alu_ctrl_fsm.sv
// Multicycle control sequencer driving the ALU's alu_control/z_flag interface.
// Accepts one MIPS instruction per instr_valid/instr_ready handshake and walks it
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB, raising datapath strobes.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   instr_valid/ready  instruction handshake (ready only in FETCH)
//   instr              32-bit MIPS instruction
//   z_flag             ALU zero flag for the current alu_control
//   mem_ready          data memory completes the access this cycle
//   alu_control        5-bit ALU operation, stable from DECODE through WB
//   alu_src_imm        reg2 operand is the extended immediate
//   shamt_sel          reg1 operand is instr[10:6]
//   reg_dst_rd         write register is rd (else rt)
//   reg_write          register file write strobe
//   hilo_write         HI/LO write strobe
//   mem_read/mem_write load/store request, held until mem_ready
//   mem_to_reg         writeback data comes from memory
//   pc_write           PC update strobe, once per instruction
//   branch_taken       PC takes the branch target (qualified by pc_write)
//   illegal            one-cycle pulse on an undecodable instruction
//   halt               SYSCALL reached; sticky until reset
module alu_ctrl_fsm #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        z_flag,
  input  logic        mem_ready,
  output logic [4:0]  alu_control,
  output logic        alu_src_imm,
  output logic        shamt_sel,
  output logic        reg_dst_rd,
  output logic        reg_write,
  output logic        hilo_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        illegal,
  output logic        halt
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [2:0] {KAlu, KLoad, KStore, KBranch, KMulDiv, KSys, KIll} kind_e;

  typedef struct packed {
    logic [4:0] code;
    kind_e      kind;
    logic       imm;
    logic       shamt;
    logic       rd;
  } dec_t;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MULDIV_CYCLES - 1);

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d.code  = 5'd0;
    d.kind  = KIll;
    d.imm   = 1'b0;
    d.shamt = 1'b0;
    d.rd    = 1'b0;
    case (i[31:26])
      6'h00: begin
        d.kind = KAlu;
        d.rd   = 1'b1;
        case (i[5:0])
          6'h26: d.code = 5'd0;
          6'h00: begin d.code = 5'd1;  d.shamt = 1'b1; end
          6'h04: d.code = 5'd2;
          6'h02: begin d.code = 5'd3;  d.shamt = 1'b1; end
          6'h22: d.code = 5'd4;
          6'h06: d.code = 5'd5;
          6'h2A: d.code = 5'd6;
          6'h0C: begin d.code = 5'd7;  d.kind = KSys; d.rd = 1'b0; end
          6'h23: d.code = 5'd8;
          6'h25: d.code = 5'd9;
          6'h27: d.code = 5'd10;
          6'h21: d.code = 5'd11;
          6'h18: begin d.code = 5'd12; d.kind = KMulDiv; end
          6'h1A: begin d.code = 5'd13; d.kind = KMulDiv; end
          6'h24: d.code = 5'd14;
          6'h20: d.code = 5'd15;
          6'h03: begin d.code = 5'd16; d.shamt = 1'b1; end
          default: begin d.kind = KIll; d.rd = 1'b0; end
        endcase
      end
      // REGIMM: only BGEZ (rt == 1) is supported
      6'h01: if (i[20:16] == 5'd1) begin d.code = 5'd21; d.kind = KBranch; end
      6'h04: begin d.code = 5'd17; d.kind = KBranch; end
      6'h05: begin d.code = 5'd18; d.kind = KBranch; end
      6'h06: begin d.code = 5'd19; d.kind = KBranch; end
      6'h07: begin d.code = 5'd20; d.kind = KBranch; end
      6'h0F: begin d.code = 5'd22; d.kind = KAlu;   d.imm = 1'b1; end
      6'h08: begin d.code = 5'd15; d.kind = KAlu;   d.imm = 1'b1; end
      6'h09: begin d.code = 5'd11; d.kind = KAlu;   d.imm = 1'b1; end
      6'h0A: begin d.code = 5'd6;  d.kind = KAlu;   d.imm = 1'b1; end
      6'h0C: begin d.code = 5'd14; d.kind = KAlu;   d.imm = 1'b1; end
      6'h0D: begin d.code = 5'd9;  d.kind = KAlu;   d.imm = 1'b1; end
      6'h0E: begin d.code = 5'd0;  d.kind = KAlu;   d.imm = 1'b1; end
      6'h23: begin d.code = 5'd15; d.kind = KLoad;  d.imm = 1'b1; end
      6'h2B: begin d.code = 5'd15; d.kind = KStore; d.imm = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic kind_e kind_of(input logic [31:0] i);
    dec_t d;
    d = decode(i);
    return d.kind;
  endfunction

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       instr_q;
  logic              pc_write_q;
  logic              br_q;
  dec_t              dec_in;
  kind_e             kind_cur;

  always_comb begin
    dec_in   = decode(instr);
    kind_cur = kind_of(instr_q);
  end

  // Store completion and branch direction are only known in the cycle itself,
  // so those two terms bypass the output registers.
  assign pc_write     = pc_write_q | (state == StMem && kind_cur == KStore && mem_ready);
  assign branch_taken = br_q & ~z_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StFetch;
      cnt         <= '0;
      instr_q     <= '0;
      alu_control <= 5'd0;
      alu_src_imm <= 1'b0;
      shamt_sel   <= 1'b0;
      reg_dst_rd  <= 1'b0;
      instr_ready <= 1'b1;
      reg_write   <= 1'b0;
      hilo_write  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      pc_write_q  <= 1'b0;
      br_q        <= 1'b0;
      illegal     <= 1'b0;
      halt        <= 1'b0;
    end else begin
      // Single-cycle strobes default low
      reg_write  <= 1'b0;
      hilo_write <= 1'b0;
      mem_to_reg <= 1'b0;
      pc_write_q <= 1'b0;
      br_q       <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        StFetch: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            alu_control <= dec_in.code;
            alu_src_imm <= dec_in.imm;
            shamt_sel   <= dec_in.shamt;
            reg_dst_rd  <= dec_in.rd;
            instr_ready <= 1'b0;
            state       <= StDecode;
            if (dec_in.kind == KIll) begin
              illegal    <= 1'b1;
              pc_write_q <= 1'b1;
            end
          end
        end
        StDecode: begin
          case (kind_cur)
            KIll: begin
              state       <= StFetch;
              instr_ready <= 1'b1;
            end
            KSys: begin
              state <= StHalt;
              halt  <= 1'b1;
            end
            KBranch: begin
              state      <= StExec;
              pc_write_q <= 1'b1;
              br_q       <= 1'b1;
            end
            default: state <= StExec;
          endcase
        end
        StExec: begin
          case (kind_cur)
            KLoad: begin
              state    <= StMem;
              mem_read <= 1'b1;
            end
            KStore: begin
              state     <= StMem;
              mem_write <= 1'b1;
            end
            KBranch: begin
              state       <= StFetch;
              instr_ready <= 1'b1;
            end
            KMulDiv: begin
              if (cnt == CntLast) begin
                cnt        <= '0;
                state      <= StWb;
                hilo_write <= 1'b1;
                pc_write_q <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state      <= StWb;
              reg_write  <= 1'b1;
              pc_write_q <= 1'b1;
            end
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (kind_cur == KLoad) begin
              state      <= StWb;
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b1;
              pc_write_q <= 1'b1;
            end else begin
              state       <= StFetch;
              instr_ready <= 1'b1;
            end
          end
        end
        StWb: begin
          state       <= StFetch;
          instr_ready <= 1'b1;
        end
        StHalt: ;
        default: begin
          state       <= StFetch;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed table, randomized instructions
// against a table-lookup reference model, and hand-written reset/halt sequences.
module tb_alu_ctrl_fsm;

  localparam int MULDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        z_flag;
  logic        mem_ready;
  logic [4:0]  alu_control;
  logic        alu_src_imm, shamt_sel, reg_dst_rd, reg_write, hilo_write;
  logic        mem_read, mem_write, mem_to_reg, pc_write, branch_taken, illegal, halt;

  int vectors = 0;
  int miscompares = 0;

  alu_ctrl_fsm #(.MULDIV_CYCLES(MULDIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .z_flag(z_flag), .mem_ready(mem_ready), .alu_control(alu_control),
    .alu_src_imm(alu_src_imm), .shamt_sel(shamt_sel), .reg_dst_rd(reg_dst_rd),
    .reg_write(reg_write), .hilo_write(hilo_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
    .branch_taken(branch_taken), .illegal(illegal), .halt(halt)
  );

  always #5 clk = ~clk;

  // Reference tables: R-type funct indexed by ALU code, and I-type opcode/code pairs
  localparam logic [5:0] RFN [17] = '{6'h26, 6'h00, 6'h04, 6'h02, 6'h22, 6'h06, 6'h2A,
                                      6'h0C, 6'h23, 6'h25, 6'h27, 6'h21, 6'h18, 6'h1A,
                                      6'h24, 6'h20, 6'h03};
  localparam logic [5:0] IOP [13] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h0F, 6'h08, 6'h09,
                                      6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
  localparam int ICODE [13] = '{17, 18, 19, 20, 22, 15, 11, 6, 14, 9, 0, 15, 15};

  // Classes: 0 illegal, 1 alu, 2 load, 3 store, 4 branch, 5 mult/div, 6 syscall
  function automatic void ref_dec(input logic [31:0] i, output int code, output int cls,
                                  output bit imm, output bit sh, output bit rd);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    code = 0; cls = 0; imm = 0; sh = 0; rd = 0;
    if (op == 6'h00) begin
      for (int k = 0; k < 17; k++) begin
        if (RFN[k] == fn) begin
          code = k;
          cls  = (k == 7) ? 6 : (k == 12 || k == 13) ? 5 : 1;
          rd   = (k != 7);
          sh   = (k == 1 || k == 3 || k == 16);
        end
      end
    end else if (op == 6'h01) begin
      if (i[20:16] == 5'd1) begin code = 21; cls = 4; end
    end else begin
      for (int k = 0; k < 13; k++) begin
        if (IOP[k] == op) begin
          code = ICODE[k];
          cls  = (k < 4) ? 4 : (op == 6'h23) ? 2 : (op == 6'h2B) ? 3 : 1;
          imm  = (k >= 4);
        end
      end
    end
  endfunction

  // {instr_ready, halt, illegal, pc_write, branch_taken, reg_write, hilo_write,
  //  mem_read, mem_write, mem_to_reg}
  function automatic logic [9:0] obs();
    return {instr_ready, halt, illegal, pc_write, branch_taken, reg_write, hilo_write,
            mem_read, mem_write, mem_to_reg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one instruction; compare every cycle against the reference model.
  // exp_code/exp_lat < 0 skip the table-level checks.
  task automatic run(input logic [31:0] ins, input bit z, input int w,
                     input int exp_code, input int exp_lat, input string tag);
    int code, cls, end_c, pc_seen;
    bit imm, sh, rd;
    logic [9:0] e;
    ref_dec(ins, code, cls, imm, sh, rd);
    case (cls)
      0: end_c = 1;
      1: end_c = 3;
      2: end_c = 4 + w;
      3: end_c = 3 + w;
      4: end_c = 2;
      default: end_c = 2 + MULDIV;
    endcase
    @(negedge clk);
    mem_ready = 1'b0;
    check($sformatf("ready_%s", tag), {31'd0, instr_ready}, 32'd1);
    instr = ins; instr_valid = 1'b1; z_flag = z;
    @(posedge clk);
    pc_seen = -1;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      mem_ready = ((cls == 2 || cls == 3) && c == 3 + w);
      #1;
      e = {1'b0, 1'b0, (cls == 0 && c == 1), (c == end_c), (cls == 4 && c == 2 && !z),
           ((cls == 1 && c == 3) || (cls == 2 && c == end_c)), (cls == 5 && c == end_c),
           (cls == 2 && c >= 3 && c <= 3 + w), (cls == 3 && c >= 3 && c <= 3 + w),
           (cls == 2 && c == end_c)};
      check($sformatf("strobes_%s_c%0d", tag, c), {22'd0, obs()}, {22'd0, e});
      if (cls != 0)
        check($sformatf("fields_%s_c%0d", tag, c),
              {24'd0, alu_control, alu_src_imm, shamt_sel, reg_dst_rd},
              {24'd0, 5'(code), imm, sh, rd});
      if (c == 1 && exp_code >= 0)
        check($sformatf("code_%s", tag), {27'd0, alu_control}, 32'(exp_code));
      if (pc_write && pc_seen < 0) pc_seen = c;
    end
    if (exp_lat >= 0) check($sformatf("latency_%s", tag), 32'(pc_seen), 32'(exp_lat));
  endtask

  typedef struct {
    logic [31:0] ins;
    bit          z;
    int          w;
    int          code;
    int          lat;
    string       name;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [31:0] r, ins;
    int code, cls, idx;
    bit imm, sh, rd, seen;

    tbl.push_back('{32'h00851020, 1'b0, 0, 15, 3, "add"});
    tbl.push_back('{32'h10850003, 1'b0, 0, 17, 2, "beq_taken"});
    tbl.push_back('{32'h10850003, 1'b1, 0, 17, 2, "beq_not"});
    tbl.push_back('{32'h8C820004, 1'b0, 3, 15, 7, "lw_wait3"});
    tbl.push_back('{32'hAC820004, 1'b0, 1, 15, 4, "sw_wait1"});
    tbl.push_back('{32'hAC820004, 1'b0, 0, 15, 3, "sw_wait0"});
    tbl.push_back('{32'h00850018, 1'b0, 0, 12, 6, "mult"});
    tbl.push_back('{32'h0085001A, 1'b0, 0, 13, 6, "div"});
    tbl.push_back('{32'h00051080, 1'b0, 0, 1, 3, "sll"});
    tbl.push_back('{32'h00051083, 1'b0, 0, 16, 3, "sra"});
    tbl.push_back('{32'h3C011234, 1'b0, 0, 22, 3, "lui"});
    tbl.push_back('{32'h38A20001, 1'b0, 0, 0, 3, "xori"});
    tbl.push_back('{32'h04A10003, 1'b0, 0, 21, 2, "bgez"});
    tbl.push_back('{32'h04A20003, 1'b0, 0, -1, 1, "regimm_bad_rt"});
    tbl.push_back('{32'hFC000000, 1'b0, 0, -1, 1, "op3f"});
    tbl.push_back('{32'h0000003F, 1'b0, 0, -1, 1, "funct3f"});

    rst = 1'b1; instr_valid = 1'b0; instr = '0; z_flag = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_strobes", {22'd0, obs()}, {22'd0, 10'b1000000000});
    check("reset_fields", {24'd0, alu_control, alu_src_imm, shamt_sel, reg_dst_rd}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i].ins, tbl[i].z, tbl[i].w, tbl[i].code, tbl[i].lat, tbl[i].name);

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      idx = $urandom_range(0, 9);
      if (idx == 0) begin
        ins = r;
      end else if (idx <= 4) begin
        idx = $urandom_range(0, 16);
        if (idx == 7) idx = 0;
        ins = {6'h00, r[25:6], RFN[idx]};
      end else if (idx == 5) begin
        ins = {6'h01, r[25:21], 5'd1, r[15:0]};
      end else begin
        idx = $urandom_range(0, 12);
        ins = {IOP[idx], r[25:0]};
      end
      ref_dec(ins, code, cls, imm, sh, rd);
      if (cls == 6) ins[5:0] = 6'h26;
      run(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, -1, $sformatf("rnd%0d", n));
    end

    // Reset while a DIV is in its EXEC hold
    @(negedge clk);
    instr = 32'h0085001A; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("div_reset_strobes", {22'd0, obs()}, {22'd0, 10'b1000000000});
    check("div_reset_code", {27'd0, alu_control}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      seen = seen | hilo_write | pc_write;
    end
    check("div_reset_no_strobe", {31'd0, seen}, 32'd0);
    check("div_reset_ready", {31'd0, instr_ready}, 32'd1);

    // SYSCALL halts with instr_valid held high until reset
    @(negedge clk);
    instr = 32'h0000000C; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("sys_decode", {22'd0, obs()}, 32'd0);
    for (int c = 2; c < 10; c++) begin
      @(negedge clk); #1;
      check($sformatf("sys_halt_c%0d", c), {22'd0, obs()}, {22'd0, 10'b0100000000});
    end
    rst = 1'b1;
    #1;
    check("sys_reset", {22'd0, obs()}, {22'd0, 10'b1000000000});
    @(negedge clk); rst = 1'b0; instr_valid = 1'b0;

    run(32'h00851020, 1'b0, 0, 15, 3, "add_after_halt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
